// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the FFT datapath blocks:
// default widths, saturation limits, divider FSM encoding.
package fxp_pkg;

    localparam int FXP_DATA_WIDTH = 16;
    localparam int FXP_FRAC_BITS  = 8;

    localparam logic [FXP_DATA_WIDTH-1:0] SAT_HI =
        {1'b0, {(FXP_DATA_WIDTH-1){1'b1}}};
    localparam logic [FXP_DATA_WIDTH-1:0] SAT_LO =
        {1'b1, {(FXP_DATA_WIDTH-1){1'b0}}};

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Signed result of width dw from a sign flag and a magnitude,
    // clamped to [-2^(dw-1), 2^(dw-1)-1]; caller keeps the low dw bits.
    function automatic logic [63:0] saturate(
        input logic        neg,
        input logic [63:0] mag,
        input int unsigned dw
    );
        logic [63:0] hi;
        logic [63:0] r;
        hi = (64'd1 << (dw - 1)) - 64'd1;
        if (!neg) begin
            r = (mag > hi) ? hi : mag;
        end else begin
            r = (mag > hi + 64'd1) ? ~hi : (~mag + 64'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// Step sequencing comes from the parent's iteration counter.
module udiv_seq #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             last_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic             done_o
);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic             done_q, done_d;

    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             fits;

    // No borrow out of the trial subtraction means the divisor fits.
    assign trial = {rem_q, quo_q[DVD_W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = ~diff[DVS_W];

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d  = fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
            quo_d  = {quo_q[DVD_W-2:0], fits};
            done_d = last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/cdiv_seq.sv
// Sequential complex divider Y = A*conj(B) / |B|^2 in signed Qm.n,
// two parallel restoring dividers behind a valid/ready handshake.
module cdiv_seq #(
    parameter int DATA_WIDTH = fxp_pkg::FXP_DATA_WIDTH,
    parameter int FRAC_BITS  = fxp_pkg::FXP_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A_real,
    input  logic [DATA_WIDTH-1:0] A_imag,
    input  logic [DATA_WIDTH-1:0] B_real,
    input  logic [DATA_WIDTH-1:0] B_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Y_real,
    output logic [DATA_WIDTH-1:0] Y_imag,
    output logic                  div_by_zero
);

    import fxp_pkg::*;

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int NW   = PW + 1;
    localparam int ITER = PW + FRAC_BITS;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
    localparam logic [DATA_WIDTH-1:0] Y_MAX =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [2:0]             st_q, st_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  yre_q, yre_d;
    logic [DATA_WIDTH-1:0]  yim_q, yim_d;
    logic                   dbz_q, dbz_d;

    logic signed [DATA_WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
    logic                         neg_re_q, neg_im_q;
    logic [PW-1:0]                den_q;

    logic signed [NW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [NW-1:0] num_re, num_im;
    logic [PW-1:0]        den_c;
    logic [PW-1:0]        mag_re, mag_im;
    logic [ITER-1:0]      dvd_re, dvd_im;
    logic [ITER-1:0]      q_re, q_im;
    logic                 done_re, done_im;

    // Products are widened first so nothing is lost before division.
    assign ar_x = NW'(ar_q);
    assign ai_x = NW'(ai_q);
    assign br_x = NW'(br_q);
    assign bi_x = NW'(bi_q);

    assign num_re = ar_x * br_x + ai_x * bi_x;
    assign num_im = ai_x * br_x - ar_x * bi_x;
    assign den_c  = PW'(br_x * br_x + bi_x * bi_x);

    assign mag_re = num_re[NW-1] ? PW'(-num_re) : PW'(num_re);
    assign mag_im = num_im[NW-1] ? PW'(-num_im) : PW'(num_im);
    assign dvd_re = {mag_re, {FRAC_BITS{1'b0}}};
    assign dvd_im = {mag_im, {FRAC_BITS{1'b0}}};

    udiv_seq #(
        .DVD_W(ITER),
        .DVS_W(PW)
    ) u_div_re (
        .clk        (clk),
        .rst        (rst),
        .start_i    (st_q == ST_MUL),
        .step_i     (st_q == ST_DIV),
        .last_i     (cnt_q == CNT_LAST),
        .dividend_i (dvd_re),
        .divisor_i  (den_c),
        .quotient_o (q_re),
        .done_o     (done_re)
    );

    udiv_seq #(
        .DVD_W(ITER),
        .DVS_W(PW)
    ) u_div_im (
        .clk        (clk),
        .rst        (rst),
        .start_i    (st_q == ST_MUL),
        .step_i     (st_q == ST_DIV),
        .last_i     (cnt_q == CNT_LAST),
        .dividend_i (dvd_im),
        .divisor_i  (den_c),
        .quotient_o (q_im),
        .done_o     (done_im)
    );

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        yre_d = yre_q;
        yim_d = yim_q;
        dbz_d = dbz_q;
        case (st_q)
            ST_IDLE: begin
                if (in_valid) st_d = ST_MUL;
            end
            ST_MUL: begin
                st_d  = ST_DIV;
                cnt_d = '0;
            end
            ST_DIV: begin
                if (cnt_q == CNT_LAST) begin
                    st_d  = ST_FIX;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                st_d = ST_DONE;
                if (den_q == '0) begin
                    yre_d = Y_MAX;
                    yim_d = Y_MAX;
                    dbz_d = 1'b1;
                end else if (done_re && done_im) begin
                    yre_d = DATA_WIDTH'(saturate(neg_re_q,
                                64'(q_re), DATA_WIDTH));
                    yim_d = DATA_WIDTH'(saturate(neg_im_q,
                                64'(q_im), DATA_WIDTH));
                    dbz_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            yre_q <= '0;
            yim_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            yre_q <= yre_d;
            yim_q <= yim_d;
            dbz_q <= dbz_d;
        end
    end

    // Datapath registers carry no state meaning, so they skip reset.
    always_ff @(posedge clk) begin
        if (st_q == ST_IDLE && in_valid) begin
            ar_q <= A_real;
            ai_q <= A_imag;
            br_q <= B_real;
            bi_q <= B_imag;
        end
        if (st_q == ST_MUL) begin
            neg_re_q <= num_re[NW-1];
            neg_im_q <= num_im[NW-1];
            den_q    <= den_c;
        end
    end

    assign in_ready    = (st_q == ST_IDLE);
    assign out_valid   = (st_q == ST_DONE);
    assign Y_real      = yre_q;
    assign Y_imag      = yim_q;
    assign div_by_zero = dbz_q;

endmodule
